// File: rtl/key_debouncer.sv
// Debounces raw active-low push-buttons into clean active-high levels with
// one-cycle press/release pulses. Define KEY_REPEAT_EN to add hold-to-repeat presses.
module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must fit in a CNT_W-bit counter");
    end

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] key_s;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];

    assign key_s = ~sync2_q;

`ifdef KEY_REPEAT_EN
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("REPEAT_PERIOD must be in 1 .. REPEAT_DELAY");
    end

    // Reloading to DELAY-PERIOD after each repeat makes the next one land PERIOD cycles later.
    localparam logic [31:0] RCNT_FIRE   = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RCNT_RELOAD = 32'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [31:0] rcnt_q [N_KEYS];
    logic [31:0] rcnt_d [N_KEYS];
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        for (int k = 0; k < N_KEYS; k++) begin
            // NOTE: every output of this block gets a default first so no path infers a latch.
            cnt_d[k]     = cnt_q[k];
            level_d[k]   = level_q[k];
            press_d[k]   = 1'b0;
            release_d[k] = 1'b0;

            if (key_s[k] == level_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                level_d[k]   = key_s[k];
                cnt_d[k]     = '0;
                press_d[k]   = key_s[k];
                release_d[k] = ~key_s[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end

`ifdef KEY_REPEAT_EN
            // Idle while released; the press and release edges both clear it, so no repeat on release.
            if (!level_q[k] || (level_d[k] != level_q[k])) begin
                rcnt_d[k] = '0;
            end else if (rcnt_q[k] == RCNT_FIRE) begin
                rcnt_d[k]  = RCNT_RELOAD;
                press_d[k] = 1'b1;
            end else begin
                rcnt_d[k] = rcnt_q[k] + 32'd1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= '0;
`ifdef KEY_REPEAT_EN
                rcnt_q[k] <= '0;
`endif
            end
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
`ifdef KEY_REPEAT_EN
                rcnt_q[k] <= rcnt_d[k];
`endif
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule
